mem_stage_wb: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs; it is the reader end of that interface.
- Resolves branch and jump decisions, runs a req/ack handshake to an external data memory, and stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds writeback.

---
 rtl/cpu_pipe_pkg.sv | 26 ++
 rtl/dmem_handshake_fsm.sv | 114 +++++++++++
 rtl/mem_stage_wb.sv | 122 ++++++++++++
 tb/tb_mem_stage_wb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pipe_pkg
// Brief   : Shared widths, handshake state encoding and MEM/WB bubble value.
// Revision: 1.0
// ============================================================================
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // A bubble only kills the writeback controls; data fields keep their last value.
  localparam wb_ctrl_t WB_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0};

endpackage
`default_nettype wire

// File: rtl/dmem_handshake_fsm.sv
`default_nettype none
// ============================================================================
// Module  : dmem_handshake_fsm
// Brief   : Data-memory req/ack handshake, request registers, stall/complete.
//           Optional abort on a stuck access when MEM_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
module dmem_handshake_fsm
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ack_i,
  output logic              idle_o,
  output logic              stall_o,
  output logic              complete_o,
  output logic              req_o,
  output logic              we_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              mem_err_o
);

  mem_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              w_timeout;
  logic              w_busy;

  assign w_busy = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;

  assign w_timeout = w_busy && !ack_i && (cnt_q == CNT_W'(TIMEOUT));
  assign cnt_d     = (w_busy && !ack_i && !w_timeout) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (w_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err_o = err_q;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
  assign mem_err_o        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end
        end
        BUSY: begin
          if (ack_i || w_timeout) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Stall is released in the completing (or aborting) cycle so upstream advances at that edge.
  assign stall_o    = rst & ((!w_busy & start_i) | (w_busy & !ack_i & !w_timeout));
  assign complete_o = w_busy & ack_i;
  assign idle_o     = !w_busy;
  assign req_o      = req_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_wb.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_wb
// Brief   : MEM stage: branch/jump resolution, data-memory access, MEM/WB reg.
//           Optional access timeout enabled by defining MEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_stage_wb #(
  parameter int DATA_W  = cpu_pipe_pkg::DATA_W,
  parameter int REG_W   = cpu_pipe_pkg::REG_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              branch_i,
  input  logic              bne_i,
  input  logic              Jump_i,
  input  logic              ALUZero_i,
  input  logic [DATA_W-1:0] IDAdder_i,
  input  logic [DATA_W-1:0] jumpaddr_i,
  input  logic [DATA_W-1:0] ALU_i,
  input  logic [DATA_W-1:0] RD2_i,
  input  logic [REG_W-1:0]  rt_rd_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic              pc_sel_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] ALU_o,
  output logic [REG_W-1:0]  rt_rd_o,
  output logic              misalign_o,
  output logic              mem_err_o
);
  import cpu_pipe_pkg::*;

  logic              w_memop;
  logic              w_misaligned;
  logic              w_taken;
  logic              w_idle;
  logic              w_complete;
  logic              w_wb_load;
  wb_ctrl_t          ctrl_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [REG_W-1:0]  rd_q;
  logic              misalign_q;

  assign w_memop      = MemRead_i | MemWrite_i;
  assign w_misaligned = |ALU_i[1:0];

  dmem_handshake_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_memop & ~w_misaligned),
    .we_i       (MemWrite_i),
    .addr_i     (ALU_i),
    .wdata_i    (RD2_i),
    .ack_i      (dmem_ack_i),
    .idle_o     (w_idle),
    .stall_o    (stall_o),
    .complete_o (w_complete),
    .req_o      (dmem_req_o),
    .we_o       (dmem_we_o),
    .addr_o     (dmem_addr_o),
    .wdata_o    (dmem_wdata_o),
    .mem_err_o  (mem_err_o)
  );

  assign w_taken     = (branch_i & ALUZero_i) | (bne_i & ~ALUZero_i);
  assign pc_sel_o    = w_taken | Jump_i;
  assign pc_target_o = Jump_i ? jumpaddr_i : IDAdder_i;
  assign flush_o     = pc_sel_o;

  assign w_wb_load = (w_idle & ~w_memop) | w_complete;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= WB_BUBBLE;
      rdata_q    <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= w_idle & w_memop & w_misaligned;
      if (w_wb_load) begin
        ctrl_q <= '{memtoreg: MemtoReg_i, regwrite: RegWrite_i};
        alu_q  <= ALU_i;
        rd_q   <= rt_rd_i;
      end else begin
        ctrl_q <= WB_BUBBLE;
      end
      // A combined read+write is treated as a write, so its load data is dropped.
      if (w_complete & MemRead_i & ~MemWrite_i) begin
        rdata_q <= dmem_rdata_i;
      end
    end
  end

  assign MemtoReg_o = ctrl_q.memtoreg;
  assign RegWrite_o = ctrl_q.regwrite;
  assign rdata_o    = rdata_q;
  assign ALU_o      = alu_q;
  assign rt_rd_o    = rd_q;
  assign misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_wb
// Brief   : Directed bench for mem_stage_wb with a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_mem_stage_wb;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i;
  logic          branch_i, bne_i, Jump_i, ALUZero_i;
  logic [DW-1:0] IDAdder_i, jumpaddr_i, ALU_i, RD2_i;
  logic [RW-1:0] rt_rd_i;
  logic          stall_o, flush_o, pc_sel_o;
  logic [DW-1:0] pc_target_o;
  logic          dmem_req_o, dmem_we_o;
  logic [DW-1:0] dmem_addr_o, dmem_wdata_o;
  logic          dmem_ack_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          MemtoReg_o, RegWrite_o;
  logic [DW-1:0] rdata_o, ALU_o;
  logic [RW-1:0] rt_rd_o;
  logic          misalign_o, mem_err_o;

  mem_stage_wb #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .branch_i(branch_i), .bne_i(bne_i), .Jump_i(Jump_i), .ALUZero_i(ALUZero_i),
    .IDAdder_i(IDAdder_i), .jumpaddr_i(jumpaddr_i), .ALU_i(ALU_i), .RD2_i(RD2_i), .rt_rd_i(rt_rd_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .rdata_o(rdata_o), .ALU_o(ALU_o), .rt_rd_o(rt_rd_o),
    .misalign_o(misalign_o), .mem_err_o(mem_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation of the stage: is an access pending, how long has it waited.
  bit            started = 1'b0;
  bit            m_pending;
  int            m_wait;
  logic          m_req, m_we, m_mtr, m_rw, m_mis, m_err;
  logic [DW-1:0] m_addr, m_wdata, m_alu, m_rdata;
  logic [RW-1:0] m_rd;

  function automatic logic aligned_memop();
    return (MemRead_i || MemWrite_i) && (ALU_i % 4 == 0);
  endfunction

  function automatic logic timed_out();
    return TO_EN && m_pending && !dmem_ack_i && (m_wait == TO);
  endfunction

  task automatic model_writeback();
    m_mtr = MemtoReg_i;
    m_rw  = RegWrite_i;
    m_alu = ALU_i;
    m_rd  = rt_rd_i;
  endtask

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      m_pending = 0; m_wait = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_mtr = 0; m_rw = 0; m_alu = 0; m_rd = 0; m_rdata = 0; m_mis = 0; m_err = 0;
    end else if (!m_pending) begin
      m_mis = 1'b0;
      if (!(MemRead_i || MemWrite_i)) begin
        model_writeback();
      end else begin
        m_mtr = 0; m_rw = 0;
        if (!aligned_memop()) begin
          m_mis = 1'b1;
        end else begin
          m_pending = 1; m_wait = 0;
          m_req = 1; m_we = MemWrite_i; m_addr = ALU_i; m_wdata = RD2_i;
        end
      end
    end else begin
      m_mis = 1'b0;
      if (dmem_ack_i) begin
        model_writeback();
        if (MemRead_i && !MemWrite_i) m_rdata = dmem_rdata_i;
        m_req = 0; m_pending = 0; m_wait = 0;
      end else if (timed_out()) begin
        m_mtr = 0; m_rw = 0; m_req = 0; m_pending = 0; m_wait = 0; m_err = 1;
      end else begin
        m_mtr = 0; m_rw = 0; m_wait++;
      end
    end
  end

  always @(negedge clk) begin
    logic e_sel, e_stall;
    logic [DW-1:0] e_tgt;
    if (started) begin
      e_sel = Jump_i || (branch_i && ALUZero_i) || (bne_i && !ALUZero_i);
      e_tgt = Jump_i ? jumpaddr_i : IDAdder_i;
      if (!rst) e_stall = 1'b0;
      else if (!m_pending) e_stall = aligned_memop();
      else e_stall = !dmem_ack_i && !timed_out();
      chk("stall", stall_o, e_stall);
      chk("pc_sel", pc_sel_o, e_sel);
      chk("flush", flush_o, e_sel);
      chk("pc_target", pc_target_o, e_tgt);
      chk("dmem_req", dmem_req_o, m_req);
      chk("dmem_we", dmem_we_o, m_we);
      chk("dmem_addr", dmem_addr_o, m_addr);
      chk("dmem_wdata", dmem_wdata_o, m_wdata);
      chk("MemtoReg", MemtoReg_o, m_mtr);
      chk("RegWrite", RegWrite_o, m_rw);
      chk("rdata", rdata_o, m_rdata);
      chk("ALU_o", ALU_o, m_alu);
      chk("rt_rd", rt_rd_o, m_rd);
      chk("misalign", misalign_o, m_mis);
      chk("mem_err", mem_err_o, m_err);
    end
  end

  // Memory responder: ack arrives after resp_delay request cycles without ack.
  int resp_delay = 0;
  initial begin
    int cnt;
    cnt = 0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      if (!dmem_req_o || dmem_ack_i) begin
        dmem_ack_i = 1'b0;
        cnt = 0;
      end else if (cnt == resp_delay) begin
        dmem_ack_i = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  task automatic set_ex(input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic [DW-1:0] alu, input logic [DW-1:0] rd2, input logic [RW-1:0] rd);
    MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r; RegWrite_i = rw;
    ALU_i = alu; RD2_i = rd2; rt_rd_i = rd;
  endtask

  // Hold the current EX/MEM inputs until the stage accepts them.
  task automatic run_op(output int stalls, output int cycles);
    logic s;
    stalls = 0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = stall_o;
      if (s) stalls++;
      @(posedge clk);
      #1;
      cycles++;
      if (!s) return;
    end
    checks++;
    errors++;
    $display("FAIL op_bound: stall still %0d after %0d cycles, required 0", stall_o, cycles);
  endtask

  initial begin
    int st, cy;
    rst = 1'b0;
    branch_i = 0; bne_i = 0; Jump_i = 0; ALUZero_i = 0;
    IDAdder_i = 0; jumpaddr_i = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);

    @(posedge clk); #1;
    chk("reset_req", dmem_req_o, 1'b0);
    chk("reset_regwrite", RegWrite_o, 1'b0);
    chk("reset_err", mem_err_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // R-type passes straight through in one cycle
    set_ex(0, 0, 0, 1, 32'h10, 0, 5);
    run_op(st, cy);
    chk("rtype_stalls", st, 0);
    chk("rtype_RegWrite", RegWrite_o, 1'b1);
    chk("rtype_ALU", ALU_o, 32'h10);
    chk("rtype_rd", rt_rd_o, 5);

    // Load with three wait cycles
    resp_delay = 3;
    set_ex(1, 0, 1, 1, 32'h40, 0, 7);
    run_op(st, cy);
    chk("load_stalls", st, 4);
    chk("load_addr", dmem_addr_o, 32'h40);
    chk("load_we", dmem_we_o, 1'b0);
    chk("load_rdata", rdata_o, 32'hDEADBEEF);
    chk("load_MemtoReg", MemtoReg_o, 1'b1);
    chk("load_rd", rt_rd_o, 7);

    // Zero-wait store
    resp_delay = 0;
    dmem_rdata_i = 32'h0BAD0BAD;
    set_ex(0, 1, 0, 0, 32'h44, 32'h1234, 3);
    run_op(st, cy);
    chk("store_cycles", cy, 2);
    chk("store_we", dmem_we_o, 1'b1);
    chk("store_wdata", dmem_wdata_o, 32'h1234);
    chk("store_RegWrite", RegWrite_o, 1'b0);
    chk("store_rdata_kept", rdata_o, 32'hDEADBEEF);

    // Branch / jump redirect
    set_ex(0, 0, 0, 0, 0, 0, 0);
    bne_i = 1; ALUZero_i = 0; IDAdder_i = 32'h100; jumpaddr_i = 32'h200;
    #1;
    chk("bne_sel", pc_sel_o, 1'b1);
    chk("bne_target", pc_target_o, 32'h100);
    chk("bne_flush", flush_o, 1'b1);
    ALUZero_i = 1;
    #1;
    chk("bne_not_taken", pc_sel_o, 1'b0);
    Jump_i = 1;
    #1;
    chk("jump_sel", pc_sel_o, 1'b1);
    chk("jump_target", pc_target_o, 32'h200);
    run_op(st, cy);
    bne_i = 0; Jump_i = 0; ALUZero_i = 0;
    branch_i = 1; ALUZero_i = 1; IDAdder_i = 32'h300;
    run_op(st, cy);
    branch_i = 0;

    // Misaligned load: no request, one-cycle pulse, bubble
    set_ex(1, 0, 1, 1, 32'h42, 0, 9);
    run_op(st, cy);
    chk("mis_stalls", st, 0);
    chk("mis_pulse", misalign_o, 1'b1);
    chk("mis_bubble", RegWrite_o, 1'b0);
    chk("mis_noreq", dmem_req_o, 1'b0);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("mis_pulse_end", misalign_o, 1'b0);

    // Reset while an access is outstanding
    resp_delay = 1000;
    set_ex(1, 0, 1, 1, 32'h80, 0, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_req", dmem_req_o, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_req", dmem_req_o, 1'b0);
    chk("rst_busy_stall", stall_o, 1'b0);
    rst = 1'b1;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    set_ex(1, 0, 1, 1, 32'h84, 0, 6);
    run_op(st, cy);
    chk("to_stalls", st, TO + 1);
    chk("to_err", mem_err_o, 1'b1);
    chk("to_req", dmem_req_o, 1'b0);
    chk("to_bubble", RegWrite_o, 1'b0);
    set_ex(0, 0, 0, 1, 32'h8, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", mem_err_o, 1'b1);
`endif

    set_ex(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
